// File: rtl/render_layer_sequencer.sv
// render_layer_sequencer
//   Frame-render sequencer. On refresh it fetches NUM_CFG config bytes from
//   VRAM over the byte-serial read bus (address high byte, then low byte,
//   then capture). It then runs the enabled draw engines in index order and
//   routes the active engine's VRAM and pixel traffic to the shared outputs.
//   Finally it requests a buffer swap and counts the completed frame.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   refresh                    start a frame (sampled in IDLE only)
//   rd_addr / rd_data          byte-serial VRAM read bus
//   draw, x_out, y_out, color  screen-buffer write port (active engine)
//   swap_buffer / buffer_swapped   swap request / acknowledge
//   layer_start / layer_done   per-engine run enable / finished flag
//   layer_rd_addr, layer_draw, layer_x, layer_y, layer_color
//                              per-engine buses, slice i = engine i
//   layer_rd_data              rd_data broadcast to every engine
//   cfg_out                    fetched config bytes, byte i at [8i+7:8i]
//   timeout_flags              sticky per-layer watchdog abort flags
//   frame_count                completed frames (wrapping)
//   busy                       high whenever not IDLE
module render_layer_sequencer #(
    parameter int          NUM_LAYERS    = 4,
    parameter int          NUM_CFG       = 3,
    parameter logic [15:0] CFG_BASE      = 16'hE8A5,
    parameter logic [7:0]  ALWAYS_ON     = 8'h01,
    parameter int          COORD_W       = 8,
    parameter int          COLOR_W       = 2,
    parameter int          LAYER_TIMEOUT = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          refresh,
    output logic [7:0]                    rd_addr,
    input  logic [7:0]                    rd_data,
    output logic                          draw,
    output logic [COORD_W-1:0]            x_out,
    output logic [COORD_W-1:0]            y_out,
    output logic [COLOR_W-1:0]            color,
    output logic                          swap_buffer,
    input  logic                          buffer_swapped,
    output logic [NUM_LAYERS-1:0]         layer_start,
    input  logic [NUM_LAYERS-1:0]         layer_done,
    input  logic [NUM_LAYERS*8-1:0]       layer_rd_addr,
    output logic [7:0]                    layer_rd_data,
    input  logic [NUM_LAYERS-1:0]         layer_draw,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0] layer_y,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    output logic [NUM_CFG*8-1:0]          cfg_out,
    output logic [NUM_LAYERS-1:0]         timeout_flags,
    output logic [15:0]                   frame_count,
    output logic                          busy
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    // cur must be able to hold NUM_LAYERS ("past the last layer")
    localparam int CUR_W = $clog2(NUM_LAYERS + 1);
    localparam int KW    = $clog2(2 * NUM_CFG + 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * NUM_CFG);
    localparam logic [15:0] TO_LAST = 16'((LAYER_TIMEOUT > 0) ? LAYER_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SELECT, S_LAYER, S_SWAP} state_t;

    state_t                r_state, w_next;
    logic [KW-1:0]         r_k;
    logic [NUM_CFG*8-1:0]  r_cfg;
    logic [CUR_W-1:0]      r_cur;
    logic [IDX_W-1:0]      r_idx;
    logic [15:0]           r_wd;
    logic [NUM_LAYERS-1:0] r_tflags;
    logic [15:0]           r_frame;

    logic [15:0]           w_fetch_addr;
    logic [NUM_LAYERS-1:0] w_en;
    logic                  w_sel_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [7:0]            w_eng_addr;
    logic                  w_eng_draw;
    logic [COORD_W-1:0]    w_eng_x;
    logic [COORD_W-1:0]    w_eng_y;
    logic [COLOR_W-1:0]    w_eng_color;
    logic                  w_eng_done;
    logic                  w_timeout;

    assign w_fetch_addr  = CFG_BASE + 16'(r_k >> 1);
    assign w_en          = r_cfg[(NUM_CFG-1)*8 +: NUM_LAYERS] | ALWAYS_ON[NUM_LAYERS-1:0];
    assign layer_rd_data = rd_data;
    assign cfg_out       = r_cfg;
    assign timeout_flags = r_tflags;
    assign frame_count   = r_frame;
    assign busy          = (r_state != S_IDLE);

    // Lowest enabled layer at or above cur: scan downwards so the last hit wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_en[i] && (CUR_W'(i) >= r_cur)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Active-engine mux
    always_comb begin
        w_eng_addr  = '0;
        w_eng_draw  = 1'b0;
        w_eng_x     = '0;
        w_eng_y     = '0;
        w_eng_color = '0;
        w_eng_done  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_eng_addr  = layer_rd_addr[i*8 +: 8];
                w_eng_draw  = layer_draw[i];
                w_eng_x     = layer_x[i*COORD_W +: COORD_W];
                w_eng_y     = layer_y[i*COORD_W +: COORD_W];
                w_eng_color = layer_color[i*COLOR_W +: COLOR_W];
                w_eng_done  = layer_done[i];
            end
        end
    end

    // Done takes priority over a coincident watchdog expiry.
    assign w_timeout = (LAYER_TIMEOUT != 0) && (r_wd == TO_LAST) && !w_eng_done;

    always_comb begin
        w_next      = r_state;
        rd_addr     = '0;
        draw        = 1'b0;
        x_out       = '0;
        y_out       = '0;
        color       = '0;
        layer_start = '0;
        swap_buffer = 1'b0;
        case (r_state)
            S_IDLE: if (refresh) w_next = S_FETCH;
            S_FETCH: begin
                // even step: high address byte, odd step: low address byte
                if (r_k < K_LAST)
                    rd_addr = r_k[0] ? w_fetch_addr[7:0] : w_fetch_addr[15:8];
                if (r_k == K_LAST) w_next = S_SELECT;
            end
            S_SELECT: w_next = w_sel_found ? S_LAYER : S_SWAP;
            S_LAYER: begin
                rd_addr = w_eng_addr;
                draw    = w_eng_draw;
                x_out   = w_eng_x;
                y_out   = w_eng_y;
                color   = w_eng_color;
                if (w_eng_done || w_timeout) w_next = S_SELECT;
                else layer_start = NUM_LAYERS'(1) << r_idx;
            end
            S_SWAP: begin
                swap_buffer = 1'b1;
                if (buffer_swapped) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_cfg    <= '0;
            r_cur    <= '0;
            r_idx    <= '0;
            r_wd     <= '0;
            r_tflags <= '0;
            r_frame  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_k   <= '0;
                    r_cur <= '0;
                end
                S_FETCH: begin
                    r_k <= r_k + KW'(1);
                    // byte i lands two steps after its high address byte
                    for (int b = 0; b < NUM_CFG; b++)
                        if (r_k == KW'(2*b + 2)) r_cfg[b*8 +: 8] <= rd_data;
                    if (r_k == K_LAST) r_cur <= '0;
                end
                S_SELECT: begin
                    if (w_sel_found) begin
                        r_idx <= w_sel_idx;
                        r_wd  <= '0;
                    end
                end
                S_LAYER: begin
                    r_wd <= r_wd + 16'd1;
                    if (w_eng_done || w_timeout) r_cur <= CUR_W'(r_idx) + CUR_W'(1);
                    if (w_timeout) r_tflags[r_idx] <= 1'b1;
                end
                S_SWAP: if (buffer_swapped) r_frame <= r_frame + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/render_layer_sequencer.md
Name: render_layer_sequencer

Overview:
Parametrised frame-render sequencer for the graphics path. On each refresh it fetches a block of configuration bytes from VRAM over the byte-serial read bus. It then runs up to NUM_LAYERS draw engines in priority order, skipping disabled layers, and routes the active engine's VRAM and screen-buffer traffic to the shared outputs. It adds a per-layer watchdog and a frame counter, then hands the frame to the buffer-swap handshake.

Parameters:
NUM_LAYERS, 4, number of draw engines (1..8); index 0 is drawn first, so the highest index lands on top.
NUM_CFG, 3, config bytes fetched per frame; the last byte is the layer-enable mask.
CFG_BASE, 16'hE8A5, VRAM address of config byte 0; byte i is at CFG_BASE+i.
ALWAYS_ON, 8'h01, layers forced enabled regardless of the mask.
COORD_W, 8, x/y width.
COLOR_W, 2, color width.
LAYER_TIMEOUT, 65535, maximum cycles per layer; 0 disables the watchdog.

Ports:
clk  in  1  clock
reset  in  1  reset: synchronous, active-high
refresh  in  1  start a frame; sampled only in IDLE
rd_addr  out  8  VRAM byte-serial address
rd_data  in  8  VRAM read data
draw  out  1  screen-buffer write strobe
x_out  out  COORD_W  pixel x
y_out  out  COORD_W  pixel y
color  out  COLOR_W  pixel color
swap_buffer  out  1  request buffer swap
buffer_swapped  in  1  swap acknowledge
layer_start  out  NUM_LAYERS  one-hot run enable per engine
layer_done  in  NUM_LAYERS  engine-finished flags
layer_rd_addr  in  NUM_LAYERS*8  per-engine rd_addr; slice i belongs to engine i
layer_rd_data  out  8  rd_data broadcast to all engines
layer_draw  in  NUM_LAYERS  per-engine draw
layer_x  in  NUM_LAYERS*COORD_W  per-engine x
layer_y  in  NUM_LAYERS*COORD_W  per-engine y
layer_color  in  NUM_LAYERS*COLOR_W  per-engine color
cfg_out  out  NUM_CFG*8  fetched config bytes; byte i in bits [8i+7:8i]
timeout_flags  out  NUM_LAYERS  sticky, bit i set when layer i was aborted
frame_count  out  16  completed frames; wraps 0xFFFF to 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous) mid-operation: state goes to IDLE, and cfg_out, timeout_flags and frame_count all clear to 0. On the next cycle layer_start=0, swap_buffer=0, draw=0, rd_addr=0, x_out/y_out/color=0.
- Outside LAYER state, draw/x_out/y_out/color are driven to 0. Outputs are never X.
- layer_rd_data always equals rd_data.
- IDLE:
  - refresh=1 -> FETCH with step counter k=0.
  - refresh is ignored in every other state.
- FETCH, one step per cycle, k = 0..2*NUM_CFG:
  - Even k=2i (i<NUM_CFG): rd_addr = high byte of CFG_BASE+i.
  - Odd k=2i+1: rd_addr = low byte of CFG_BASE+i.
  - At k=2i+2: rd_data is captured into cfg byte i.
  - Total fetch time is 2*NUM_CFG+1 cycles. The step after the last capture goes to SELECT with cur=0.
- Enable mask: en = cfg byte NUM_CFG-1 [NUM_LAYERS-1:0] | ALWAYS_ON[NUM_LAYERS-1:0].
- SELECT (1 cycle):
  - Finds the lowest enabled index >= cur and goes to LAYER with idx set to it.
  - If no enabled index remains, goes to SWAP.
  - rd_addr=0 in this state.
- LAYER:
  - rd_addr = layer_rd_addr[idx]; draw/x/y/color come from engine idx.
  - layer_start[idx]=1 while layer_done[idx]=0. All other start bits are 0.
  - In the cycle layer_done[idx]=1: start drops combinationally, cur=idx+1, next state is SELECT.
  - Watchdog counter clears on entry to LAYER. If it reaches LAYER_TIMEOUT-1 with done still low: start drops, timeout_flags[idx] is set, cur=idx+1, next state is SELECT.
  - If done and timeout occur in the same cycle, done wins and no flag is set.
  - idx = NUM_LAYERS-1 completing goes to SELECT, which then goes to SWAP.
- SWAP:
  - swap_buffer=1 until buffer_swapped=1.
  - In that cycle: frame_count increments, next state is IDLE, swap_buffer is 0 from the next cycle.
  - If buffer_swapped is already high on entry, SWAP lasts 1 cycle.
- timeout_flags clear only on reset.

Test Plan:
- Default params, VRAM E8A5=0x10, E8A6=0x20, E8A7=0x00, pulse refresh -> rd_addr sequence E8,A5,E8,A6,E8,A7 -> cfg_out=0x002010 after 7 cycles; only layer 0 runs; SWAP follows; frame_count=1.
- Mask 0x0A -> layers run in order 0,1,3; layer_start[2] never asserts; each SELECT lasts 1 cycle.
- Engine 1 asserts draw with x=5, y=7, color=2 -> outputs match exactly; engine 0 outputs are ignored while idx=1.
- LAYER_TIMEOUT=16, engine 1 never asserts done -> start drops after 16 cycles; timeout_flags=0b0010; layer 3 still runs.
- Reset asserted mid-LAYER with frame_count=5 -> next cycle IDLE, layer_start=0, frame_count=0, cfg_out=0.
- refresh pulsed during SWAP with buffer_swapped held low for 10 cycles -> no restart; swap_buffer stays high for 10 cycles; frame_count=0xFFFF wraps to 0.
